// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_HOLD,
    PC_REDIR,
    PC_BR,
    PC_CALL,
    PC_RET,
    PC_CALLRET
  } pc_sel_e;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; push+pop together replaces the top entry.
// Latency: top/count update on the edge after push/pop; no backpressure, a full push overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [XLEN-1:0]              push_data,
  output logic [XLEN-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;

  // ptr names the next free slot; once full it also names the oldest entry
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + PW'(1);
      if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
    end else if (pop && !push) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[pop ? top_idx : ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: redirect > branch > stall > call/ret > sequential, with a return-address stack.
// Latency: every input acts on the next edge, all outputs registered; stall holds pc except for redirect/branch.
module fetch_pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              PC_STEP   = 1,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_target,
  input  logic                       branch_taken,
  input  logic [XLEN-1:0]            branch_target,
  input  logic                       call,
  input  logic                       ret,
  output logic [XLEN-1:0]            pc,
  output logic                       pc_redirected,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_underflow
);

  pc_sel_e         sel;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            underflow_nxt;
  logic            redirected_nxt;
  logic            ras_push;
  logic            ras_pop;

  assign pc_inc    = pc + XLEN'(PC_STEP);
  assign ras_empty = (ras_count == '0);

  always_comb begin
    sel           = PC_SEQ;
    underflow_nxt = 1'b0;
    if (redirect_valid)     sel = PC_REDIR;
    else if (branch_taken)  sel = PC_BR;
    else if (stall)         sel = PC_HOLD;
    else if (call && ret)   sel = ras_empty ? PC_CALL : PC_CALLRET;
    else if (ret) begin
      sel           = ras_empty ? PC_SEQ : PC_RET;
      underflow_nxt = ras_empty;
    end
    else if (call)          sel = PC_CALL;
  end

  always_comb begin
    pc_nxt         = pc_inc;
    redirected_nxt = 1'b1;
    unique case (sel)
      PC_REDIR:              pc_nxt = redirect_target;
      PC_BR, PC_CALL:        pc_nxt = branch_target;
      PC_RET, PC_CALLRET:    pc_nxt = ras_top;
      PC_HOLD: begin
        pc_nxt         = pc;
        redirected_nxt = 1'b0;
      end
      default:               redirected_nxt = 1'b0;
    endcase
  end

  assign ras_push = (sel == PC_CALL) || (sel == PC_CALLRET);
  assign ras_pop  = (sel == PC_RET)  || (sel == PC_CALLRET);

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_VEC;
      pc_redirected <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      pc_redirected <= redirected_nxt;
      ras_underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed vector bench for fetch_pc_gen (XLEN=32, PC_STEP=1, RESET_VEC=0, RAS_DEPTH=4).
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        call;
  logic        ret;
  logic [31:0] pc;
  logic        pc_redirected;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_pc_gen #(
    .XLEN      (32),
    .PC_STEP   (1),
    .RESET_VEC (32'h0),
    .RAS_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .call            (call),
    .ret             (ret),
    .pc              (pc),
    .pc_redirected   (pc_redirected),
    .ras_count       (ras_count),
    .ras_underflow   (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic        rv;
    logic [31:0] rt;
    logic        br;
    logic [31:0] bt;
    logic        ca;
    logic        re;
    logic [31:0] e_pc;
    logic        e_rd;
    logic [2:0]  e_cnt;
    logic        e_uf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(string nm, logic st, logic rv, logic [31:0] rt,
                               logic br, logic [31:0] bt, logic ca, logic re,
                               logic [31:0] e_pc, logic e_rd, logic [2:0] e_cnt, logic e_uf);
    vec_t v;
    v.name = nm; v.st = st; v.rv = rv; v.rt = rt; v.br = br; v.bt = bt;
    v.ca = ca; v.re = re; v.e_pc = e_pc; v.e_rd = e_rd; v.e_cnt = e_cnt; v.e_uf = e_uf;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] e_pc, logic e_rd, logic [2:0] e_cnt, logic e_uf);
    n_vec++;
    if (pc !== e_pc || pc_redirected !== e_rd || ras_count !== e_cnt || ras_underflow !== e_uf) begin
      n_miss++;
      $display("FAIL %s: got pc=%h redir=%b cnt=%0d uf=%b, want pc=%h redir=%b cnt=%0d uf=%b",
               nm, pc, pc_redirected, ras_count, ras_underflow, e_pc, e_rd, e_cnt, e_uf);
    end
  endtask

  task automatic drive(vec_t v);
    stall           = v.st;
    redirect_valid  = v.rv;
    redirect_target = v.rt;
    branch_taken    = v.br;
    branch_target   = v.bt;
    call            = v.ca;
    ret             = v.re;
  endtask

  task automatic apply(vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(v.name, v.e_pc, v.e_rd, v.e_cnt, v.e_uf);
  endtask

  initial begin
    //            name        st rv rt            br bt            ca re  e_pc          rd cnt uf
    // idle after reset release
    tbl.push_back(mkv("idle1",    0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1,        0, 0, 0));
    tbl.push_back(mkv("idle2",    0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h2,        0, 0, 0));
    tbl.push_back(mkv("idle3",    0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h3,        0, 0, 0));
    // stall, branch under stall, redirect over branch
    tbl.push_back(mkv("seq4",     0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h4,        0, 0, 0));
    tbl.push_back(mkv("seq5",     0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h5,        0, 0, 0));
    tbl.push_back(mkv("stall1",   1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h5,        0, 0, 0));
    tbl.push_back(mkv("stall2",   1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h5,        0, 0, 0));
    tbl.push_back(mkv("br_stall", 1, 0, 32'h0,        1, 32'h40,       0, 0, 32'h40,       1, 0, 0));
    tbl.push_back(mkv("redir_br", 1, 1, 32'h80,       1, 32'h40,       0, 0, 32'h80,       1, 0, 0));
    tbl.push_back(mkv("redir_ca", 0, 1, 32'h10,       0, 32'h0,        1, 1, 32'h10,       1, 0, 0));
    // call then return
    tbl.push_back(mkv("call100",  0, 0, 32'h0,        0, 32'h100,      1, 0, 32'h100,      1, 1, 0));
    tbl.push_back(mkv("seq101",   0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h101,      0, 1, 0));
    tbl.push_back(mkv("seq102",   0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h102,      0, 1, 0));
    tbl.push_back(mkv("ret11",    0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h11,       1, 0, 0));
    // nested calls past capacity
    tbl.push_back(mkv("to1",      0, 1, 32'h1,        0, 32'h0,        0, 0, 32'h1,        1, 0, 0));
    tbl.push_back(mkv("call21",   0, 0, 32'h0,        0, 32'h21,       1, 0, 32'h21,       1, 1, 0));
    tbl.push_back(mkv("call41",   0, 0, 32'h0,        0, 32'h41,       1, 0, 32'h41,       1, 2, 0));
    tbl.push_back(mkv("stall_cr", 1, 0, 32'h0,        0, 32'h77,       1, 1, 32'h41,       0, 2, 0));
    tbl.push_back(mkv("call61",   0, 0, 32'h0,        0, 32'h61,       1, 0, 32'h61,       1, 3, 0));
    tbl.push_back(mkv("call81",   0, 0, 32'h0,        0, 32'h81,       1, 0, 32'h81,       1, 4, 0));
    tbl.push_back(mkv("callA1",   0, 0, 32'h0,        0, 32'ha1,       1, 0, 32'ha1,       1, 4, 0));
    tbl.push_back(mkv("ret82",    0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h82,       1, 3, 0));
    tbl.push_back(mkv("ret62",    0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h62,       1, 2, 0));
    tbl.push_back(mkv("ret42",    0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h42,       1, 1, 0));
    tbl.push_back(mkv("ret22",    0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h22,       1, 0, 0));
    tbl.push_back(mkv("ret_uf",   0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h23,       0, 0, 1));
    tbl.push_back(mkv("uf_clr",   0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h24,       0, 0, 0));
    // underflow pulse, then call+ret replace-top
    tbl.push_back(mkv("to7",      0, 1, 32'h7,        0, 32'h0,        0, 0, 32'h7,        1, 0, 0));
    tbl.push_back(mkv("ret_uf7",  0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8,        0, 0, 1));
    tbl.push_back(mkv("uf_one",   0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h9,        0, 0, 0));
    tbl.push_back(mkv("to2f",     0, 1, 32'h2f,       0, 32'h0,        0, 0, 32'h2f,       1, 0, 0));
    tbl.push_back(mkv("call50",   0, 0, 32'h0,        0, 32'h50,       1, 0, 32'h50,       1, 1, 0));
    tbl.push_back(mkv("callret",  0, 0, 32'h0,        0, 32'h999,      1, 1, 32'h30,       1, 1, 0));
    tbl.push_back(mkv("ret51",    0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h51,       1, 0, 0));
    tbl.push_back(mkv("cr_empty", 0, 0, 32'h0,        0, 32'h200,      1, 1, 32'h200,      1, 1, 0));
    tbl.push_back(mkv("ret52",    0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h52,       1, 0, 0));
    // branch wins over call; PC wrap-around
    tbl.push_back(mkv("br_call",  0, 0, 32'h0,        1, 32'h300,      1, 0, 32'h300,      1, 0, 0));
    tbl.push_back(mkv("to_max",   0, 1, 32'hffffffff, 0, 32'h0,        0, 0, 32'hffffffff, 1, 0, 0));
    tbl.push_back(mkv("wrap0",    0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mkv("wrap1",    0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1,        0, 0, 0));

    reset = 1'b1;
    drive(mkv("zero", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0));
    #2;
    check("reset_state", 32'h0, 1'b0, 3'd0, 1'b0);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    check("first_seq", 32'h1, 1'b0, 3'd0, 1'b0);
    apply(mkv("pre_call", 0, 0, 32'h0, 0, 32'h16, 1, 0, 32'h16, 1, 1, 0));
    apply(mkv("pre_17",   0, 0, 32'h0, 0, 32'h0,  0, 0, 32'h17, 0, 1, 0));

    // async reset mid-cycle with a call pending on the inputs
    drive(mkv("pend", 0, 0, 32'h0, 0, 32'h99, 1, 0, 32'h0, 0, 0, 0));
    #2 reset = 1'b1;
    #1;
    check("async_reset", 32'h0, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    check("reset_hold", 32'h0, 1'b0, 3'd0, 1'b0);
    drive(mkv("zero", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0));
    #2 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Parametrised fetch-stage program-counter generator. It is the successor to the single-branch PC register.
- Adds configurable width, step and reset vector.
- Adds fetch stall and a pipeline redirect (flush) path.
- Adds call/return support through a circular return-address stack (RAS).
- Sits at the front of the pipeline, drives the instruction-memory address, and takes redirect/branch resolution from later stages.

Parameters:
XLEN, 32, PC and address width in bits.
PC_STEP, 1, increment per sequential fetch (1 = word-addressed memory).
RESET_VEC, 0, PC value loaded on reset; XLEN bits wide.
RAS_DEPTH, 4, number of RAS entries; power of two, minimum 2.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hold PC; suppresses sequential advance and call/ret.
redirect_valid  in  1  flush/exception redirect from a later stage.
redirect_target  in  XLEN  redirect address.
branch_taken  in  1  resolved taken branch.
branch_target  in  XLEN  branch/call target address.
call  in  1  fetched instruction is a call; jump to branch_target and push return address.
ret  in  1  fetched instruction is a return; jump to popped RAS address.
pc  out  XLEN  current fetch address.
pc_redirected  out  1  high in the cycle pc holds a non-sequential value.
ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
ras_underflow  out  1  one-cycle pulse: ret issued with RAS empty.

Behaviour:
- Reset: asynchronous and active-high. Clock is clk; reset is asynchronous, active-high.
  - On reset assertion: pc=RESET_VEC, pc_redirected=0, ras_count=0, ras_underflow=0, RAS pointer=0.
  - RAS entry contents are don't-care after reset.
  - Reset asserted mid-operation discards everything in flight, including any pending push/pop.
- All updates happen on the rising edge of clk. Next-PC selection priority, highest first:
  1. redirect_valid: pc<=redirect_target. Stall, call and ret are ignored. RAS is untouched.
  2. branch_taken: pc<=branch_target. Applies even when stall=1. call and ret are ignored.
  3. stall: pc holds its value; call and ret are ignored (no push/pop).
  4. call & ret together: pc<=RAS top; the top entry is overwritten with pc+PC_STEP; ras_count is unchanged. If RAS is empty, this behaves as call alone.
  5. ret: if ras_count>0, pc<=top, pop, ras_count-1. If ras_count=0, pc<=pc+PC_STEP and ras_underflow=1 for one cycle.
  6. call: pc<=branch_target; push pc+PC_STEP; ras_count+1, saturating at RAS_DEPTH. When full, push wraps the circular pointer and overwrites the oldest entry.
  7. default: pc<=pc+PC_STEP.
- All PC arithmetic is modulo 2^XLEN; wrap-around from all-ones to 0 is silent.
- pc_redirected: registered. It is 1 in the cycle after an edge where case 1, 2, 4, 5 (non-empty RAS) or 6 was taken; otherwise 0.
- ras_underflow: registered, high for exactly one cycle.
- The RAS pointer is a $clog2(RAS_DEPTH)-bit index: it increments on push, decrements on pop, and wraps naturally.
- Latency: every input affects pc on the next edge; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package pc_pkg:
  - typedef enum pc_sel_e {PC_SEQ, PC_HOLD, PC_REDIR, PC_BR, PC_CALL, PC_RET, PC_CALLRET}.
  - Default XLEN and RESET_VEC constants.
- One sub-module, pc_ras: circular stack parametrised by XLEN and RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, count.
  - Supports simultaneous push+pop as replace-top.
- Next-PC selection is one combinational block in fetch_pc_gen, driven by pc_sel_e.

Test Plan (XLEN=32, PC_STEP=1, RESET_VEC=0, RAS_DEPTH=4):
1. Reset asserted asynchronously mid-cycle with pc=0x17 -> pc=0 immediately, ras_count=0. After release, 3 idle cycles give pc 1,2,3 and pc_redirected=0.
2. pc=5, stall=1 for 2 cycles, then branch_taken=1 with branch_target=0x40 while stall=1 -> pc holds 5,5, then 0x40 with pc_redirected=1. Same cycle with redirect_valid=1, redirect_target=0x80 -> pc=0x80.
3. pc=0x10, call with target 0x100 -> pc=0x100, ras_count=1. Advance to 0x102, then ret -> pc=0x11, ras_count=0, pc_redirected=1.
4. Five nested calls from pc=1,0x21,0x41,0x61,0x81 (each target = pc+0x20) -> ras_count saturates at 4. Four rets return 0x82,0x62,0x42,0x22. Fifth ret -> ras_underflow=1, pc sequential.
5. ret with RAS empty at pc=7 -> pc=8, ras_underflow pulses exactly one cycle. Simultaneous call+ret with top=0x30 at pc=0x50 -> pc=0x30, top becomes 0x51, count unchanged.
6. pc=0xFFFFFFFF, no control inputs -> pc=0x00000000, pc_redirected=0.
